// File: rtl/pool_asm_pkg.sv
// Shared types and sizing helpers for the pool frame assembler.
package pool_asm_pkg;

    // FILL: collecting pixels; HOLD: complete frame presented to the pool stage
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } asmState_e;

    function automatic int calc_total(input int h, input int w, input int d);
        return h * w * d;
    endfunction

    // Counter width; never narrower than one bit so a 1-element frame still elaborates
    function automatic int idxWidth(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/pool_asm_index.sv
// Frame element index counter: clear to zero, increment, flag on final element.
module pool_asm_index #(
    parameter int TOTAL = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [IDX_W-1:0] idx,
    output logic             isLast
);

    // Clear has priority so a misaligned or final pixel always restarts at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idx <= '0;
        else if (clear)
            idx <= '0;
        else if (inc)
            idx <= idx + 1'b1;
    end

    assign isLast = (idx == IDX_W'(TOTAL - 1));

endmodule

// File: rtl/pool_frame_assembler.sv
// Gathers a raster-order pixel stream into a flat frame vector for the 2x2 max-pool.
// Optional macro POOL_ASM_RELU_EN: negative pixels are stored as zero.
module pool_frame_assembler
    import pool_asm_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int InputH     = 28,
    parameter  int InputW     = 28,
    parameter  int Depth      = 1,
    localparam int TOTAL      = calc_total(InputH, InputW, Depth),
    localparam int IDX_W      = idxWidth(TOTAL)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic [0:TOTAL*DATA_WIDTH-1]   frame_data,
    output logic                          frame_valid,
    input  logic                          frame_ack,
    output logic                          frame_err
);

    asmState_e             state, nextState;
    logic [IDX_W-1:0]      idx;
    logic                  isLast;
    logic                  accept, misaligned, complete, wrEn;
    logic [DATA_WIDTH-1:0] pixel;
    logic [DATA_WIDTH-1:0] frameMem [TOTAL];

    assign accept     = in_valid && in_ready;
    // An early in_last drops that pixel and restarts the frame
    assign misaligned = accept && in_last && !isLast;
    // The final element completes the frame whether or not in_last came with it
    assign complete   = accept && isLast;
    assign wrEn       = accept && !misaligned;

    pool_asm_index #(
        .TOTAL (TOTAL),
        .IDX_W (IDX_W)
    ) uIndex (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (misaligned || complete || (state == HOLD && frame_ack)),
        .inc    (wrEn && !isLast),
        .idx    (idx),
        .isLast (isLast)
    );

    // Pixel conditioning before storage
    always_comb begin
`ifdef POOL_ASM_RELU_EN
        pixel = in_data[DATA_WIDTH-1] ? '0 : in_data;
`else
        pixel = in_data;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= FILL;
        else
            state <= nextState;
    end

    // Next state: final accept enters HOLD, acknowledge returns to FILL
    always_comb begin
        nextState = state;
        case (state)
            FILL: if (complete)  nextState = HOLD;
            HOLD: if (frame_ack) nextState = FILL;
            default:             nextState = FILL;
        endcase
    end

    // Handshake outputs are pure functions of state, so HOLD blocks all accepts
    always_comb begin
        in_ready    = (state == FILL);
        frame_valid = (state == HOLD);
    end

    // Error pulse lands in the cycle after the offending accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frame_err <= 1'b0;
        else
            frame_err <= misaligned || (complete && !in_last);
    end

    // Frame storage; a restart leaves old contents in place until overwritten
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TOTAL; k++)
                frameMem[k] <= '0;
        end else if (wrEn) begin
            frameMem[idx] <= pixel;
        end
    end

    // Flatten storage onto the pool-stage bus, element k at k*DATA_WIDTH
    always_comb begin
        frame_data = '0;
        for (int k = 0; k < TOTAL; k++)
            frame_data[k*DATA_WIDTH +: DATA_WIDTH] = frameMem[k];
    end

endmodule

// File: tb/tb_pool_frame_assembler.sv
// Scoreboard bench for pool_frame_assembler (4x4x1 frames, 16-bit pixels).
module tb_pool_frame_assembler;

    localparam int DW    = 16;
    localparam int H     = 4;
    localparam int W     = 4;
    localparam int D     = 1;
    localparam int TOTAL = H * W * D;

    typedef struct {
        logic                ready;
        logic                valid;
        logic                err;
        logic                chk;
        logic [0:TOTAL*DW-1] frame;
    } exp_t;

    logic                clk;
    logic                rst_n;
    logic [DW-1:0]       in_data;
    logic                in_valid;
    logic                in_last;
    logic                in_ready;
    logic [0:TOTAL*DW-1] frame_data;
    logic                frame_valid;
    logic                frame_ack;
    logic                frame_err;

    int checks = 0;
    int fails  = 0;

    exp_t expQ[$];

    // Reference model state: pixels gathered so far, whether a frame is held
    bit                  mHold;
    logic [DW-1:0]       mPix[$];
    logic [0:TOTAL*DW-1] mFrame;

    pool_frame_assembler #(
        .DATA_WIDTH (DW),
        .InputH     (H),
        .InputW     (W),
        .Depth      (D)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [0:TOTAL*DW-1] act, input logic [0:TOTAL*DW-1] want);
        checks++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // Drive one cycle, predict the post-edge outputs, queue the prediction at the edge
    task automatic step(input logic v, input logic [DW-1:0] d, input logic l, input logic a);
        exp_t          e;
        logic [DW-1:0] p;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        frame_ack = a;
        e.err     = 1'b0;
        if (!mHold) begin
            if (v) begin
                p = d;
`ifdef POOL_ASM_RELU_EN
                if (d[DW-1]) p = '0;
`endif
                if (l && mPix.size() < TOTAL - 1) begin
                    mPix.delete();
                    e.err = 1'b1;
                end else begin
                    mPix.push_back(p);
                    if (mPix.size() == TOTAL) begin
                        for (int k = 0; k < TOTAL; k++)
                            mFrame[k*DW +: DW] = mPix[k];
                        mHold = 1'b1;
                        e.err = !l;
                        mPix.delete();
                    end
                end
            end
        end else if (a) begin
            mHold = 1'b0;
        end
        e.ready = !mHold;
        e.valid = mHold;
        e.chk   = mHold;
        e.frame = mFrame;
        @(posedge clk);
        expQ.push_back(e);
        #1;
    endtask

    task automatic doReset();
        exp_t e;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        frame_ack = 1'b0;
        mHold     = 1'b0;
        mPix.delete();
        mFrame    = '0;
        e.ready   = 1'b1;
        e.valid   = 1'b0;
        e.err     = 1'b0;
        e.chk     = 1'b1;
        e.frame   = '0;
        @(posedge clk);
        expQ.push_back(e);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic sendFrame(input logic [DW-1:0] base, input logic withLast);
        for (int i = 0; i < TOTAL; i++)
            step(1'b1, base + DW'(i), withLast && (i == TOTAL - 1), 1'b0);
    endtask

    // Monitor: every negedge with a pending prediction is compared against the DUT
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                cmp("in_ready",    {{(TOTAL*DW-1){1'b0}}, in_ready},    {{(TOTAL*DW-1){1'b0}}, e.ready});
                cmp("frame_valid", {{(TOTAL*DW-1){1'b0}}, frame_valid}, {{(TOTAL*DW-1){1'b0}}, e.valid});
                cmp("frame_err",   {{(TOTAL*DW-1){1'b0}}, frame_err},   {{(TOTAL*DW-1){1'b0}}, e.err});
                if (e.chk)
                    cmp("frame_data", frame_data, e.frame);
            end
        end
    end

    initial begin
        logic [DW-1:0] d;
        logic          v, l, a;
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        frame_ack = 1'b0;
        doReset();
        doReset();

        // Clean frame 1..16, then hold 20 cycles with in_valid pressure, then ack
        sendFrame(16'h0001, 1'b1);
        for (int i = 0; i < 20; i++)
            step(1'b1, DW'($urandom), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);   // ack in FILL is ignored

        // Early in_last on pixel 7, then a clean frame
        for (int i = 0; i < 7; i++)
            step(1'b1, 16'h0100 + DW'(i), i == 6, 1'b0);
        sendFrame(16'h0200, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);

        // Frame with no in_last still completes and flags an error
        sendFrame(16'h0300, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);

        // Reset after 9 accepted pixels, then a full frame from index 0
        for (int i = 0; i < 9; i++)
            step(1'b1, 16'h0400 + DW'(i), 1'b0, 1'b0);
        doReset();
        sendFrame(16'h0500, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);

        // Sign handling: negative and max-positive pixels interleaved
        for (int i = 0; i < TOTAL; i++)
            step(1'b1, (i % 2 == 0) ? 16'hFFF0 : 16'h7FFF, i == TOTAL - 1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);

        // Random traffic, mostly aligned frames with occasional stray in_last
        for (int i = 0; i < 800; i++) begin
            v = ($urandom_range(0, 9) < 7);
            d = DW'($urandom);
            if (mPix.size() == TOTAL - 1)
                l = ($urandom_range(0, 7) != 0);
            else
                l = ($urandom_range(0, 39) == 0);
            a = ($urandom_range(0, 2) == 0);
            step(v, d, l, a);
        end

        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d predictions left, expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
